// File: rtl/tc_pkg.sv
// Shared definitions for the TC register bank: write-port operation encoding.
package tc_pkg;

  localparam logic [1:0] WR_NONE  = 2'b00;
  localparam logic [1:0] WR_WRITE = 2'b01;
  localparam logic [1:0] WR_INC   = 2'b10;
  localparam logic [1:0] WR_CLEAR = 2'b11;

endpackage

// File: rtl/tc_read_port.sv
// One read port of the register bank: posedge output register with enable
// gating; addresses past DEPTH read as zero.
module tc_read_port
  import tc_pkg::*;
#(
  parameter  int SIZE   = 8,
  parameter  int DEPTH  = 8,
  localparam int ADDR_W = $clog2(DEPTH)
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       en_i,
  input  logic [ADDR_W-1:0]          addr_i,
  input  logic [DEPTH-1:0][SIZE-1:0] regs_i,
  output logic [SIZE-1:0]            data_o
);

  logic            in_range;
  logic [SIZE-1:0] data_d;
  logic [SIZE-1:0] data_q;

  // Only a non-power-of-two DEPTH leaves unused address codes.
  if (DEPTH == (1 << ADDR_W)) begin : g_pow2
    assign in_range = 1'b1;
  end else begin : g_npow2
    assign in_range = (32'(addr_i) < DEPTH);
  end

  always_comb begin
    data_d = '0;
    if (en_i && in_range) begin
      data_d = regs_i[addr_i];
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      data_q <= '0;
    end else begin
      data_q <= data_d;
    end
  end

  assign data_o = data_q;

endmodule

// File: rtl/tc_register_bank.sv
// DEPTH x SIZE register file: one write port (write/increment/clear-all)
// updating on the falling edge, two read ports registered on the rising edge.
module tc_register_bank
  import tc_pkg::*;
#(
  parameter  int SIZE   = 8,
  parameter  int DEPTH  = 8,
  localparam int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [1:0]        wr_mode,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [SIZE-1:0]   wr_data,
  input  logic              rd_en_a,
  input  logic [ADDR_W-1:0] rd_addr_a,
  output logic [SIZE-1:0]   out_a,
  input  logic              rd_en_b,
  input  logic [ADDR_W-1:0] rd_addr_b,
  output logic [SIZE-1:0]   out_b,
  output logic              wrap
);

  logic [DEPTH-1:0][SIZE-1:0] regs_d;
  logic [DEPTH-1:0][SIZE-1:0] regs_q;
  logic                       wrap_d;
  logic                       wrap_q;
  logic                       wr_in_range;

  if (DEPTH == (1 << ADDR_W)) begin : g_pow2
    assign wr_in_range = 1'b1;
  end else begin : g_npow2
    assign wr_in_range = (32'(wr_addr) < DEPTH);
  end

  // Unknown modes fall to the default arm, so nothing changes.
  always_comb begin
    regs_d = regs_q;
    wrap_d = 1'b0;
    case (wr_mode)
      WR_WRITE: begin
        if (wr_in_range) begin
          regs_d[wr_addr] = wr_data;
        end
      end
      WR_INC: begin
        if (wr_in_range) begin
          regs_d[wr_addr] = regs_q[wr_addr] + SIZE'(1);
          wrap_d          = &regs_q[wr_addr];
        end
      end
      WR_CLEAR: regs_d = '0;
      default: ;
    endcase
  end

  always_ff @(negedge clk or negedge rst) begin
    if (!rst) begin
      regs_q <= '0;
      wrap_q <= 1'b0;
    end else begin
      regs_q <= regs_d;
      wrap_q <= wrap_d;
    end
  end

  assign wrap = wrap_q;

  // The falling-edge write lands before the next rising-edge read.
  tc_read_port #(.SIZE(SIZE), .DEPTH(DEPTH)) u_port_a (
    .clk_i  (clk),
    .rst_ni (rst),
    .en_i   (rd_en_a),
    .addr_i (rd_addr_a),
    .regs_i (regs_q),
    .data_o (out_a)
  );

  tc_read_port #(.SIZE(SIZE), .DEPTH(DEPTH)) u_port_b (
    .clk_i  (clk),
    .rst_ni (rst),
    .en_i   (rd_en_b),
    .addr_i (rd_addr_b),
    .regs_i (regs_q),
    .data_o (out_b)
  );

endmodule

// File: tb/tb_tc_register_bank.sv
// Bench for tc_register_bank: a DEPTH=8 and a DEPTH=6 instance driven with
// identical stimulus and checked against a reference model via a scoreboard.
module tb_tc_register_bank;
  import tc_pkg::*;

  // ---------------- clock / reset ----------------
  logic       clk;
  logic       rst;
  logic [1:0] wr_mode;
  logic [2:0] wr_addr;
  logic [7:0] wr_data;
  logic       rd_en_a;
  logic [2:0] rd_addr_a;
  logic       rd_en_b;
  logic [2:0] rd_addr_b;
  logic [7:0] out_a8, out_b8, out_a6, out_b6;
  logic       wrap8, wrap6;

  initial clk = 1'b1;
  always #5 clk = ~clk;

  tc_register_bank #(.SIZE(8), .DEPTH(8)) dut8 (
    .clk(clk), .rst(rst), .wr_mode(wr_mode), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_en_a(rd_en_a), .rd_addr_a(rd_addr_a), .out_a(out_a8),
    .rd_en_b(rd_en_b), .rd_addr_b(rd_addr_b), .out_b(out_b8), .wrap(wrap8)
  );

  tc_register_bank #(.SIZE(8), .DEPTH(6)) dut6 (
    .clk(clk), .rst(rst), .wr_mode(wr_mode), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_en_a(rd_en_a), .rd_addr_a(rd_addr_a), .out_a(out_a6),
    .rd_en_b(rd_en_b), .rd_addr_b(rd_addr_b), .out_b(out_b6), .wrap(wrap6)
  );

  // ---------------- scoreboard ----------------
  localparam int W = 34;
  logic [W-1:0] exp_q[$];
  logic [7:0]   m8[8];
  logic [7:0]   m6[8];  // entries 6 and 7 are never written
  int           n_chk;
  int           n_err;

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < 8; i++) begin
      m8[i] = 8'h00;
      m6[i] = 8'h00;
    end
  endtask

  // ---------------- driver ----------------
  // Called at posedge+1; drives one game tick and checks the read results.
  task automatic tick(input logic [1:0] mode, input logic [2:0] wa, input logic [7:0] wd,
                      input logic ea, input logic [2:0] aa,
                      input logic eb, input logic [2:0] ab);
    logic [7:0]   ea8, eb8, ea6, eb6;
    logic         w8, w6;
    logic [W-1:0] exp;
    wr_mode = mode; wr_addr = wa; wr_data = wd;
    rd_en_a = ea; rd_addr_a = aa; rd_en_b = eb; rd_addr_b = ab;
    w8 = 1'b0;
    w6 = 1'b0;
    case (mode)
      WR_WRITE: begin
        m8[wa] = wd;
        if (wa < 3'd6) m6[wa] = wd;
      end
      WR_INC: begin
        w8 = (m8[wa] == 8'hFF);
        m8[wa] = m8[wa] + 8'd1;
        if (wa < 3'd6) begin
          w6 = (m6[wa] == 8'hFF);
          m6[wa] = m6[wa] + 8'd1;
        end
      end
      WR_CLEAR: model_clear();
      default: ;
    endcase
    ea8 = ea ? m8[aa] : 8'h00;
    eb8 = eb ? m8[ab] : 8'h00;
    ea6 = (ea && aa < 3'd6) ? m6[aa] : 8'h00;
    eb6 = (eb && ab < 3'd6) ? m6[ab] : 8'h00;
    exp_q.push_back({w6, eb6, ea6, w8, eb8, ea8});
    @(negedge clk);
    @(posedge clk);
    #1;
    exp = exp_q.pop_front();
    check("out_a8", out_a8, exp[7:0]);
    check("out_b8", out_b8, exp[15:8]);
    check("wrap8", {7'd0, wrap8}, {7'd0, exp[16]});
    check("out_a6", out_a6, exp[24:17]);
    check("out_b6", out_b6, exp[32:25]);
    check("wrap6", {7'd0, wrap6}, {7'd0, exp[33]});
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_out_a8"}, out_a8, 8'h00);
    check({tag, "_out_b8"}, out_b8, 8'h00);
    check({tag, "_wrap8"}, {7'd0, wrap8}, 8'h00);
    check({tag, "_out_a6"}, out_a6, 8'h00);
    check({tag, "_out_b6"}, out_b6, 8'h00);
    check({tag, "_wrap6"}, {7'd0, wrap6}, 8'h00);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    n_chk = 0;
    n_err = 0;
    model_clear();
    rst = 1'b0;
    wr_mode = WR_NONE; wr_addr = '0; wr_data = '0;
    rd_en_a = 1'b0; rd_addr_a = '0; rd_en_b = 1'b0; rd_addr_b = '0;
    #1;
    check_all_zero("init");
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b1;

    // write then read in the same tick; port B disabled
    tick(WR_WRITE, 3'd2, 8'hA5, 1'b1, 3'd2, 1'b0, 3'd2);

    // increment through the all-ones boundary
    tick(WR_WRITE, 3'd5, 8'hFE, 1'b1, 3'd5, 1'b0, 3'd0);
    tick(WR_INC,   3'd5, 8'h00, 1'b1, 3'd5, 1'b1, 3'd2);
    tick(WR_INC,   3'd5, 8'h00, 1'b1, 3'd5, 1'b0, 3'd0);
    tick(WR_NONE,  3'd5, 8'h00, 1'b1, 3'd5, 1'b1, 3'd5);

    // fill every address, clear all, read everything back on both ports
    for (int i = 0; i < 8; i++) begin
      tick(WR_WRITE, 3'(i), 8'h10 + 8'(i), 1'b1, 3'(i), 1'b1, 3'(7 - i));
    end
    tick(WR_CLEAR, 3'd3, 8'hEE, 1'b1, 3'd3, 1'b1, 3'd4);
    for (int i = 0; i < 8; i++) begin
      tick(WR_NONE, 3'd0, 8'h00, 1'b1, 3'(i), 1'b1, 3'(7 - i));
    end

    // both ports on the register being written
    tick(WR_WRITE, 3'd1, 8'h3C, 1'b0, 3'd0, 1'b0, 3'd0);
    tick(WR_WRITE, 3'd1, 8'h77, 1'b1, 3'd1, 1'b1, 3'd1);

    // out-of-range addresses on the DEPTH=6 instance
    tick(WR_WRITE, 3'd4, 8'h44, 1'b0, 3'd0, 1'b0, 3'd0);
    tick(WR_WRITE, 3'd7, 8'h99, 1'b1, 3'd7, 1'b1, 3'd4);
    tick(WR_WRITE, 3'd6, 8'hFF, 1'b1, 3'd6, 1'b1, 3'd7);
    tick(WR_INC,   3'd6, 8'h00, 1'b1, 3'd6, 1'b0, 3'd0);
    for (int i = 0; i < 6; i++) begin
      tick(WR_NONE, 3'd0, 8'h00, 1'b1, 3'(i), 1'b1, 3'(5 - i));
    end

    // randomised traffic; writes bias towards values near the wrap point
    for (int n = 0; n < 300; n++) begin
      int         r;
      logic [1:0] mode;
      logic [7:0] wd;
      r = $urandom_range(0, 15);
      if (r < 2)       mode = WR_NONE;
      else if (r < 9)  mode = WR_WRITE;
      else if (r < 15) mode = WR_INC;
      else             mode = WR_CLEAR;
      wd = ($urandom_range(0, 3) == 0) ? 8'hFF - 8'($urandom_range(0, 2))
                                       : 8'($urandom_range(0, 255));
      tick(mode, 3'($urandom_range(0, 7)), wd,
           1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)),
           1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)));
    end

    // asynchronous reset mid-run, with writes presented while it is held
    tick(WR_WRITE, 3'd3, 8'h5A, 1'b1, 3'd3, 1'b1, 3'd3);
    tick(WR_INC,   3'd3, 8'h00, 1'b1, 3'd3, 1'b1, 3'd3);
    #2;
    rst = 1'b0;
    #1;
    check_all_zero("rst_async");
    model_clear();
    wr_mode = WR_WRITE; wr_addr = 3'd3; wr_data = 8'h55;
    rd_en_a = 1'b1; rd_addr_a = 3'd3; rd_en_b = 1'b1; rd_addr_b = 3'd3;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk); @(posedge clk); #1;
      check_all_zero("rst_held");
    end
    rst = 1'b1;
    tick(WR_NONE, 3'd0, 8'h00, 1'b1, 3'd3, 1'b0, 3'd0);
    tick(WR_NONE, 3'd0, 8'h00, 1'b1, 3'd2, 1'b1, 3'd5);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/tc_register_bank.md
Name: tc_register_bank

Overview:
- Parametrised successor to the single TC register.
- Holds DEPTH registers of SIZE bits, with one write port and two independent read ports.
- Write port supports write, increment and clear-all modes.
- Keeps game timing: state updates on falling clk edge; read outputs are captured on rising clk edge.
- Used wherever a level instantiates a multi-register "register file" component in place of several single registers.

Parameters:
- SIZE, 8, data width of each register in bits (>=1).
- DEPTH, 8, number of registers (>=2; need not be a power of two).
- ADDR_W, $clog2(DEPTH), address width; derived, not overridden.

Ports:
- clk  input  1  clock; state changes on negedge, read outputs on posedge.
- rst  input  1  asynchronous, active-low reset (0 = reset).
- wr_mode  input  2  write operation: 00 none, 01 write, 10 increment, 11 clear-all.
- wr_addr  input  ADDR_W  target register for write and increment.
- wr_data  input  SIZE  data for write mode.
- rd_en_a  input  1  read port A load enable.
- rd_addr_a  input  ADDR_W  read port A address.
- out_a  output  SIZE  read port A data.
- rd_en_b  input  1  read port B load enable.
- rd_addr_b  input  ADDR_W  read port B address.
- out_b  output  SIZE  read port B data.
- wrap  output  1  pulses on an increment that wrapped.

Behaviour:
- Reset (rst=0, asynchronous, any time): all registers, out_a, out_b and wrap go to 0 immediately.
  - Held while rst=0; no edges take effect.
  - Released synchronously to nothing: the first edge after rst=1 operates normally.
- Storage update on negedge clk:
  - 01: reg[wr_addr] <= wr_data.
  - 10: reg[wr_addr] <= reg[wr_addr] + 1, modulo 2^SIZE.
    - wrap <= 1 iff the old value was all ones; otherwise wrap <= 0.
  - 11: every reg <= 0; wr_addr and wr_data ignored.
  - 00: no change.
  - wrap <= 0 for every mode other than 10. wrap is valid for one full cycle (negedge to negedge).
- Read on posedge clk, independently per port:
  - rd_en=1: out <= reg[rd_addr].
  - rd_en=0: out <= 0. Explicit 0, never Z, replacing the old tri0 pull-down.
- Latency:
  - A value written at negedge N is visible on out at the following posedge.
  - Write followed by read in the same game tick returns the new value. No bypass logic is needed; edge ordering provides it.
- Both ports may address the same register, including wr_addr; each port returns the same stored value.
- Out-of-range address (addr >= DEPTH, only when DEPTH is not a power of two):
  - Write and increment are ignored; wrap <= 0.
  - Read returns 0.
- Outputs hold their value between posedges. The enables are sampled only at posedge.
- No X propagation: all storage is reset; an unknown wr_mode must not corrupt other registers in simulation (treat as 00).

Decomposition:
- Shared package tc_pkg:
  - Write-mode encoding constants: WR_NONE=2'b00, WR_WRITE=2'b01, WR_INC=2'b10, WR_CLEAR=2'b11.
  - A clog2 helper function if the toolflow lacks $clog2.
- One natural sub-module: tc_read_port (SIZE, DEPTH).
  - Posedge output register, enable gating and out-of-range zeroing.
  - Instantiated twice.
- Storage array and write/increment/clear logic stay in the top module.

Test Plan:
- Reset: rst=0 mid-simulation after writes -> out_a=out_b=0, wrap=0 immediately; with rd_en_a=1, rd_addr_a=3 after release, out_a=0x00.
- Write/read: wr_mode=01, wr_addr=2, wr_data=0xA5; same cycle rd_en_a=1, rd_addr_a=2 -> out_a=0xA5 at next posedge; rd_en_b=0 -> out_b=0x00.
- Increment wrap: write 0xFE to reg5, then two increments -> reg5 goes 0xFF (wrap=0), then 0x00 (wrap=1 for exactly one cycle, then 0).
- Clear-all: fill regs 0..7 with 0x10..0x17, then wr_mode=11 -> reading every address on both ports returns 0x00.
- Dual-port collision: reg1=0x3C; rd_addr_a=rd_addr_b=1, both enabled, concurrent wr_mode=01 wr_addr=1 wr_data=0x77 -> both outputs 0x77.
- Non-power-of-two: DEPTH=6; write 0x99 to addr 7 -> ignored; read addr 7 -> 0x00; regs 0..5 unchanged.
